// File: rtl/tt_sched_pkg.sv
// tt_sched_pkg: shared FSM states, slot record and default sizes for the TX scheduler
package tt_sched_pkg;
    localparam int DEF_NUM_SLOTS         = 8;
    localparam int DEF_GTB_WIDTH         = 64;
    localparam int DEF_INIT_PULSE_CYCLES = 6;
    localparam int DEF_LEN_WIDTH         = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_WAIT} state_e;

    // One schedule table entry; widths follow the default time base and length sizes
    typedef struct packed {
        logic [31:0]              period;
        logic [DEF_GTB_WIDTH-1:0] next_rel;
        logic [7:0]               port_id;
        logic [DEF_LEN_WIDTH-1:0] msg_len;
    } slot_t;
endpackage

// File: rtl/tt_prio_arbiter.sv
// tt_prio_arbiter: picks the lowest-index set request, one-hot and encoded
module tt_prio_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    // Scan from the top so the lowest set index is the one left standing
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        any = |req;
    end
endmodule

// File: rtl/tt_tx_scheduler.sv
// tt_tx_scheduler: releases table slots on the global time base and serves them one at a time
module tt_tx_scheduler
    import tt_sched_pkg::*;
#(
    parameter int NUM_SLOTS         = DEF_NUM_SLOTS,
    parameter int GTB_WIDTH         = DEF_GTB_WIDTH,
    parameter int INIT_PULSE_CYCLES = DEF_INIT_PULSE_CYCLES,
    parameter int LEN_WIDTH         = DEF_LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [GTB_WIDTH-1:0]         GTB,
    input  logic                         sched_en,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
    input  logic [31:0]                  cfg_period,
    input  logic [GTB_WIDTH-1:0]         cfg_phase,
    input  logic [7:0]                   cfg_port_id,
    input  logic [LEN_WIDTH-1:0]         cfg_msg_len,
    output logic                         INIT_AXI_TXN,
    output logic [7:0]                   PORT_ID_WR,
    output logic [LEN_WIDTH-1:0]         MSG_LENGTH_WR,
    input  logic                         txn_done,
    output logic                         busy,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
    output logic [NUM_SLOTS-1:0]         overrun,
    input  logic                         overrun_clr
);
    localparam int IW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(INIT_PULSE_CYCLES + 1);

    slot_t                slot_q [NUM_SLOTS];
    slot_t                slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] pending_q, pending_d, overrun_q, overrun_d;
    logic [NUM_SLOTS-1:0] rel, gnt, arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_lat_q, done_lat_d, init_q, init_d;
    logic [7:0]           port_q, port_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [IW-1:0]        act_q, act_d;

    tt_prio_arbiter #(.N(NUM_SLOTS)) u_arb (
        .req(pending_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    // Table writes, release compare, pending set/clear and sticky overrun per slot
    always_comb begin
        gnt       = (state_q == ST_IDLE) ? arb_gnt : '0;
        rel       = '0;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i]    = slot_q[i];
            rel[i]       = sched_en && slot_q[i].period != '0 && GTB >= slot_q[i].next_rel;
            pending_d[i] = rel[i] | (pending_q[i] & ~gnt[i]);
            overrun_d[i] = (rel[i] & pending_q[i] & ~gnt[i]) | (overrun_q[i] & ~overrun_clr);
            if (rel[i])
                slot_d[i].next_rel = slot_q[i].next_rel + DEF_GTB_WIDTH'(slot_q[i].period);
            if (cfg_we && cfg_idx == IW'(i)) begin
                slot_d[i]    = '{period: cfg_period, next_rel: cfg_phase,
                                 port_id: cfg_port_id, msg_len: cfg_msg_len};
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    // Serve one slot: grant in IDLE, fixed-length start pulse in INIT, wait for completion
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_lat_d = done_lat_q;
        init_d     = init_q;
        port_d     = port_q;
        len_d      = len_q;
        act_d      = act_q;
        case (state_q)
            ST_IDLE: if (arb_any) begin
                state_d    = ST_INIT;
                init_d     = 1'b1;
                cnt_d      = '0;
                done_lat_d = 1'b0;
                port_d     = slot_q[arb_idx].port_id;
                len_d      = slot_q[arb_idx].msg_len;
                act_d      = arb_idx;
            end
            ST_INIT: begin
                done_lat_d = done_lat_q | txn_done;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(INIT_PULSE_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                    init_d  = 1'b0;
                end
            end
            ST_WAIT: state_d = (done_lat_q || txn_done) ? ST_IDLE : ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // All state registers; reset aborts any transfer and empties the table
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            done_lat_q <= 1'b0;
            init_q     <= 1'b0;
            port_q     <= '0;
            len_q      <= '0;
            act_q      <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_lat_q <= done_lat_d;
            init_q     <= init_d;
            port_q     <= port_d;
            len_q      <= len_d;
            act_q      <= act_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign INIT_AXI_TXN  = init_q;
    assign PORT_ID_WR    = port_q;
    assign MSG_LENGTH_WR = len_q;
    assign busy          = state_q != ST_IDLE;
    assign active_slot   = act_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_tt_tx_scheduler.sv
// tb_tt_tx_scheduler: directed scenarios plus random traffic against a transaction-level scoreboard
module tb_tt_tx_scheduler;
    localparam int NS  = 8;
    localparam int IPC = 6;

    logic        clk = 1'b0;
    logic        rst, sched_en, cfg_we, txn_done, overrun_clr;
    logic [63:0] GTB, cfg_phase;
    logic [2:0]  cfg_idx, active_slot;
    logic [31:0] cfg_period, cfg_msg_len, MSG_LENGTH_WR;
    logic [7:0]  cfg_port_id, PORT_ID_WR, overrun;
    logic        INIT_AXI_TXN, busy;

    tt_tx_scheduler dut (
        .clk(clk), .rst(rst), .GTB(GTB), .sched_en(sched_en), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_period(cfg_period), .cfg_phase(cfg_phase),
        .cfg_port_id(cfg_port_id), .cfg_msg_len(cfg_msg_len), .INIT_AXI_TXN(INIT_AXI_TXN),
        .PORT_ID_WR(PORT_ID_WR), .MSG_LENGTH_WR(MSG_LENGTH_WR), .txn_done(txn_done),
        .busy(busy), .active_slot(active_slot), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, cyc = 0;
    bit hold = 0, fast = 0, gtb_run = 1;

    // Reference model: slot table, pending set, overrun flags and one server
    logic [31:0] m_per [NS];
    logic [63:0] m_nrel [NS];
    logic [7:0]  m_port [NS];
    logic [31:0] m_len [NS];
    logic [NS-1:0] m_pend = '0, m_ovr = '0, gm;
    logic [7:0]  m_out_port = '0;
    logic [31:0] m_out_len = '0;
    logic [2:0]  m_out_slot = '0;
    bit serving = 0, done_seen = 0, m_busy = 0, m_init = 0, rl;
    int g = 0, c = 0, k, j;

    typedef struct {int slot; int at;} exp_t;
    exp_t q[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    endfunction

    // A transfer granted at cycle g ends after its 6-cycle pulse plus one WAIT cycle,
    // or the cycle after the first completion pulse, whichever is later
    function automatic int free_at(input int gg, input int cc);
        return (gg + IPC + 2 > cc + 1) ? gg + IPC + 2 : cc + 1;
    endfunction

    always @(posedge clk) begin
        k = cyc;
        if (rst) begin
            m_pend = '0; m_ovr = '0; serving = 0; done_seen = 0; q.delete();
            m_out_port = '0; m_out_len = '0; m_out_slot = '0;
            for (int i = 0; i < NS; i++) begin
                m_per[i] = '0; m_nrel[i] = '0; m_port[i] = '0; m_len[i] = '0;
            end
        end else begin
            if (serving && done_seen && k >= free_at(g, c)) serving = 0;
            if (serving && !done_seen && txn_done && k > g) begin done_seen = 1; c = k; end
            gm = '0;
            if (!serving && m_pend != '0) begin
                j = 0;
                for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) j = i;
                gm[j] = 1'b1; serving = 1; g = k; done_seen = 0;
                m_out_port = m_port[j]; m_out_len = m_len[j]; m_out_slot = 3'(j);
                q.push_back('{slot: j, at: k + 1});
            end
            for (int i = 0; i < NS; i++) begin
                rl = sched_en && m_per[i] != 0 && GTB >= m_nrel[i];
                if (cfg_we && int'(cfg_idx) == i) begin
                    m_per[i] = cfg_period; m_nrel[i] = cfg_phase; m_port[i] = cfg_port_id;
                    m_len[i] = cfg_msg_len; m_pend[i] = 1'b0; m_ovr[i] = 1'b0;
                end else begin
                    if (rl && m_pend[i] && !gm[i]) m_ovr[i] = 1'b1;
                    else if (overrun_clr) m_ovr[i] = 1'b0;
                    if (rl) begin m_nrel[i] = m_nrel[i] + 64'(m_per[i]); m_pend[i] = 1'b1; end
                    else if (gm[i]) m_pend[i] = 1'b0;
                end
            end
        end
        cyc++;
        m_busy = serving && !(done_seen && cyc >= free_at(g, c));
        m_init = serving && cyc > g && cyc <= g + IPC;
    end

    bit prev_init = 0;
    int width = 0;
    exp_t e;

    // Monitor: per-cycle output compare and scoreboard pop on each new transfer
    always @(negedge clk) begin
        chk("init_axi_txn", INIT_AXI_TXN, m_init);
        chk("busy", busy, m_busy);
        chk("port_id_wr", PORT_ID_WR, m_out_port);
        chk("msg_length_wr", MSG_LENGTH_WR, m_out_len);
        chk("active_slot", active_slot, m_out_slot);
        chk("overrun", overrun, m_ovr);
        if (INIT_AXI_TXN && !prev_init) begin
            if (q.size() == 0) chk("unexpected_txn", INIT_AXI_TXN, 0);
            else begin
                e = q.pop_front();
                chk("txn_cycle", cyc, e.at);
                chk("txn_slot", active_slot, e.slot);
            end
        end
        if (INIT_AXI_TXN) width++;
        else if (prev_init) begin chk("init_width", width, IPC); width = 0; end
        prev_init = INIT_AXI_TXN;
    end

    // Core stand-in: one completion pulse per transfer after a random delay
    initial begin
        txn_done = 0;
        forever begin
            @(negedge clk);
            if (INIT_AXI_TXN) begin
                while (hold) @(negedge clk);
                repeat (fast ? 1 : $urandom_range(0, 12)) @(negedge clk);
                txn_done = 1;
                @(negedge clk);
                txn_done = 0;
                while (INIT_AXI_TXN) @(negedge clk);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (gtb_run) GTB = GTB + 1;
        cfg_we = 0;
        overrun_clr = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input int idx, input logic [31:0] per, input logic [63:0] ph,
                       input logic [7:0] pid, input logic [31:0] len);
        step();
        cfg_we = 1; cfg_idx = 3'(idx); cfg_period = per; cfg_phase = ph;
        cfg_port_id = pid; cfg_msg_len = len;
    endtask

    task automatic run_to(input logic [63:0] t);
        for (int n = 0; n < 2000 && GTB != t; n++) step();
        chk("run_to_gtb", GTB, t);
    endtask

    task automatic wait_init(input logic v, input string nm);
        for (int n = 0; n < 60 && INIT_AXI_TXN !== v; n++) step();
        chk(nm, INIT_AXI_TXN, v);
    endtask

    logic [63:0] p;

    initial begin
        rst = 1; sched_en = 0; cfg_we = 0; cfg_idx = 0; cfg_period = 0; cfg_phase = 0;
        cfg_port_id = 0; cfg_msg_len = 0; overrun_clr = 0; GTB = 0;
        run(3);
        chk("rst_busy", busy, 0);
        chk("rst_init", INIT_AXI_TXN, 0);
        chk("rst_port", PORT_ID_WR, 0);
        chk("rst_len", MSG_LENGTH_WR, 0);
        chk("rst_slot", active_slot, 0);
        chk("rst_overrun", overrun, 0);
        rst = 0; GTB = 150; sched_en = 1;

        // Single periodic slot: start pulse two cycles after GTB reaches the phase, then every period
        cfg(0, 100, 200, 2, 5);
        run_to(201);
        chk("t1_before_rise", INIT_AXI_TXN, 0);
        step();
        chk("t1_rise", INIT_AXI_TXN, 1);
        chk("t1_port", PORT_ID_WR, 2);
        chk("t1_len", MSG_LENGTH_WR, 5);
        run_to(301);
        chk("t1_second_before", INIT_AXI_TXN, 0);
        step();
        chk("t1_second_rise", INIT_AXI_TXN, 1);

        // Two slots released together: the lower index goes first
        cfg(0, 0, 0, 0, 0);
        p = GTB + 30;
        cfg(1, 1000, p, 11, 7);
        cfg(3, 1000, p, 33, 9);
        run_to(p + 2);
        chk("t2_first_slot", active_slot, 1);
        chk("t2_first_port", PORT_ID_WR, 11);
        for (int n = 0; n < 80 && active_slot != 3; n++) step();
        chk("t2_second_slot", active_slot, 3);
        chk("t2_second_port", PORT_ID_WR, 33);
        chk("t2_second_len", MSG_LENGTH_WR, 9);
        cfg(1, 0, 0, 0, 0);
        cfg(3, 0, 0, 0, 0);
        run(30);

        // Completion withheld: repeated releases flag overrun, clear drops it, drain with releases off
        hold = 1;
        cfg(2, 10, GTB + 5, 4, 3);
        run(40);
        chk("t3_overrun_set", overrun[2], 1);
        sched_en = 0;
        step();
        overrun_clr = 1;
        step();
        chk("t3_overrun_clr", overrun[2], 0);
        hold = 0;
        run(60);
        chk("t3_drained", busy, 0);
        cfg(2, 0, 0, 0, 0);
        sched_en = 1;
        run(5);

        // Completion during the start pulse: a single WAIT cycle follows it
        fast = 1;
        cfg(4, 50, GTB + 3, 9, 9);
        wait_init(1, "t4_rise");
        wait_init(0, "t4_fall");
        chk("t4_wait_cycle", busy, 1);
        step();
        chk("t4_idle_after", busy, 0);
        fast = 0;
        cfg(4, 0, 0, 0, 0);
        run(10);

        // Reset while waiting for completion aborts the transfer
        hold = 1;
        cfg(5, 500, GTB + 2, 7, 7);
        run(12);
        chk("t5_in_wait", busy, 1);
        chk("t5_wait_init", INIT_AXI_TXN, 0);
        rst = 1;
        step();
        rst = 0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_init", INIT_AXI_TXN, 0);
        chk("t5_rst_port", PORT_ID_WR, 0);
        hold = 0;
        run(8);
        chk("t5_stays_idle", busy, 0);

        // Time base jump: catch-up releases one per cycle, overrun from the second on
        gtb_run = 0; GTB = 0;
        cfg(0, 100, 0, 1, 1);
        run(3);
        GTB = 1000;
        run(20);
        chk("t6_catchup_overrun", overrun[0], 1);
        cfg(0, 0, 0, 0, 0);
        gtb_run = 1;
        run(40);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 19))
                0: cfg($urandom_range(0, NS - 1), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 60),
                       GTB + 64'($urandom_range(0, 30)), 8'($urandom), $urandom);
                1: begin step(); overrun_clr = 1; end
                2: begin step(); sched_en = $urandom_range(0, 3) != 0; end
                default: step();
            endcase
        end
        sched_en = 0;
        run(250);
        chk("final_queue_empty", q.size(), 0);
        chk("final_idle", busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tt_tx_scheduler.md
TT_TX_SCHEDULER -- requirements
Module: tt_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of schedule table entries.
REQ-002 SHALL have parameter GTB_WIDTH, default 64: width of the global time base.
REQ-003 SHALL have parameter INIT_PULSE_CYCLES, default 6: cycles INIT_AXI_TXN is held high per transfer.
REQ-004 SHALL have parameter LEN_WIDTH, default 32: message length width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: sole clock.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port GTB, input, GTB_WIDTH: global time base count, clk-synchronous.
REQ-009 SHALL have port sched_en, input, 1: release enable.
REQ-010 SHALL have port cfg_we, input, 1: slot write strobe.
REQ-011 SHALL have port cfg_idx, input, clog2(NUM_SLOTS): slot index.
REQ-012 SHALL have port cfg_period, input, 32: release period in GTB ticks; 0 disables the slot.
REQ-013 SHALL have port cfg_phase, input, GTB_WIDTH: absolute first release time.
REQ-014 SHALL have port cfg_port_id, input, 8: destination port id.
REQ-015 SHALL have port cfg_msg_len, input, LEN_WIDTH: message length.
REQ-016 SHALL have port INIT_AXI_TXN, output, 1: write-start request to the core.
REQ-017 SHALL have port PORT_ID_WR, output, 8: port id of the active transfer.
REQ-018 SHALL have port MSG_LENGTH_WR, output, LEN_WIDTH: length of the active transfer.
REQ-019 SHALL have port txn_done, input, 1: single-cycle completion pulse from the core.
REQ-020 SHALL have port busy, output, 1: FSM not IDLE.
REQ-021 SHALL have port active_slot, output, clog2(NUM_SLOTS): slot being served.
REQ-022 SHALL have port overrun, output, NUM_SLOTS: sticky per-slot overrun flags.
REQ-023 SHALL have port overrun_clr, input, 1: clears all overrun flags.

Function
REQ-024 SHALL write a slot on cfg_we by storing period, port_id and msg_len, setting next_rel = cfg_phase, and clearing that slot's pending and overrun bits.
REQ-025 SHALL release slot i in any cycle with sched_en=1, period_i!=0 and unsigned GTB >= next_rel_i, by setting pending_i and adding period_i to next_rel_i (one release per slot per cycle).
REQ-026 SHALL set overrun_i on a release while pending_i is already set, except when slot i is granted in the same cycle (pending stays set, no overrun).
REQ-027 SHALL catch up after a GTB jump of k periods at one release per cycle, flagging overrun from the second release onward.
REQ-028 SHALL implement FSM states IDLE, INIT, WAIT.
REQ-029 SHALL, in IDLE with any pending bit set, grant the lowest pending index: clear its pending bit, register PORT_ID_WR, MSG_LENGTH_WR and active_slot, and go to INIT.
REQ-030 SHALL hold INIT_AXI_TXN=1 for exactly INIT_PULSE_CYCLES cycles in INIT, then go to WAIT.
REQ-031 SHALL make INIT_AXI_TXN a registered output that rises 2 cycles after the cycle in which the release compare is true, when the FSM is idle.
REQ-032 SHALL latch a txn_done seen during INIT and leave WAIT on the first WAIT cycle if latched, otherwise on txn_done; WAIT goes to IDLE.
REQ-033 SHALL ignore txn_done in IDLE.
REQ-034 SHALL hold PORT_ID_WR and MSG_LENGTH_WR stable from INIT entry until the next grant.
REQ-035 SHALL let a cfg_we to the active slot leave the in-flight transfer running, unaltered.
REQ-036 SHALL, with sched_en=0, stop releases while the FSM keeps draining pending slots.
REQ-037 SHALL give overrun_clr priority below a simultaneous new overrun set (set wins).

Reset
REQ-038 SHALL on rst clear FSM to IDLE, INIT_AXI_TXN, busy, active_slot, PORT_ID_WR, MSG_LENGTH_WR, pending, overrun, all periods and all next_rel values, aborting any transfer mid-operation.

Structure
REQ-039 SHALL place FSM state enum, slot record typedef (period, next_rel, port_id, msg_len) and default parameter constants in package tt_sched_pkg.
REQ-040 SHALL implement the lowest-index pending selection as sub-module tt_prio_arbiter.

Verification
REQ-041 SHALL cover: slot0 period=100, phase=200, port=2, len=5 -> INIT_AXI_TXN high 6 cycles starting 2 cycles after GTB=200, PORT_ID_WR=2, MSG_LENGTH_WR=5; next at GTB=300.
REQ-042 SHALL cover: slots 1 and 3 released in the same cycle -> slot1 served first, slot3 served after slot1's txn_done.
REQ-043 SHALL cover: slot2 period=10 with txn_done withheld 30 cycles -> overrun[2]=1; overrun_clr -> 0.
REQ-044 SHALL cover: txn_done pulsed during INIT -> FSM goes WAIT to IDLE in one cycle.
REQ-045 SHALL cover: rst asserted during WAIT -> next cycle busy=0, INIT_AXI_TXN=0, pending=0.
REQ-046 SHALL cover: GTB jumps from 0 to 1000 with slot0 phase=0, period=100 -> 10 catch-up releases, overrun[0]=1.
